// File: rtl/spi_i2s_pkg.sv
// Shared encodings and helpers for the multi-channel I2S/LJ/TDM transmit shifter.
package spi_i2s_pkg;

  localparam logic [1:0] MODE_I2S = 2'd0;
  localparam logic [1:0] MODE_LJ  = 2'd1;
  localparam logic [1:0] MODE_TDM = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  localparam int UNDRN_MAX = 255;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Counter width with a floor of one bit, so single-slot or single-bit configs stay legal.
  function automatic int cnt_w(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

endpackage

// File: rtl/spi_i2s_frm_cnt.sv
// Bit and slot position counters for one frame, with look-ahead values for framing.
module spi_i2s_frm_cnt
  import spi_i2s_pkg::*;
#(
  parameter int SLOT_W = 32,
  parameter int NUM_CH = 2,
  parameter int BW     = cnt_w(SLOT_W),
  parameter int CW     = cnt_w(NUM_CH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic          last_bit,
  output logic          last_slot,
  output logic [BW-1:0] next_bcnt,
  output logic [CW-1:0] next_scnt
);

  logic [BW-1:0] bcnt;
  logic [CW-1:0] scnt;

  // Terminal-count decode and the position the counters move to on the next advance.
  always_comb begin
    last_bit  = (bcnt == BW'(SLOT_W - 1));
    last_slot = (scnt == CW'(NUM_CH - 1));
    next_bcnt = last_bit ? '0 : bcnt + 1'b1;
    next_scnt = scnt;
    if (last_bit) next_scnt = last_slot ? '0 : scnt + 1'b1;
  end

  // Counter registers: cleared while loading, stepped once per shifted bit.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      bcnt <= '0;
      scnt <= '0;
    end else if (adv) begin
      bcnt <= next_bcnt;
      scnt <= next_scnt;
    end
  end

endmodule

// File: rtl/spi_i2s_tx_mc.sv
// Multi-channel serial transmit shifter: pops slot words from a FIFO and
// serialises them in I2S, left-justified or TDM framing.
//
//   state    | meaning
//   ST_IDLE  | stopped, sdo/ws low, waiting for en
//   ST_LOAD  | requesting slot 0 of a new frame, no underflow accounting
//   ST_SHIFT | shifting one bit per clock, reloading at each slot boundary
module spi_i2s_tx_mc
  import spi_i2s_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SLOT_W = 32,
  parameter int NUM_CH = 2
) (
  input  logic                      i2s_clk_shft_tx,
  input  logic                      rst,
  input  logic                      en,
  input  logic [1:0]                mode,
  input  logic                      msb_lsb,
  input  logic [DATA_W-1:0]         tx_dat,
  input  logic                      tx_vld,
  output logic                      tx_rdy,
  output logic [cnt_w(NUM_CH)-1:0]  tx_ch,
  output logic                      sdo,
  output logic                      ws,
  output logic                      busy,
  output logic                      undrn,
  input  logic                      undrn_clr,
  output logic [7:0]                undrn_cnt
);

  localparam int BW   = cnt_w(SLOT_W);
  localparam int CW   = cnt_w(NUM_CH);
  localparam int HALF = NUM_CH / 2;

  state_t            state, state_nxt;
  logic              last_bit, last_slot;
  logic [BW-1:0]     next_bcnt;
  logic [CW-1:0]     next_scnt, ws_slot;
  logic              cnt_clr, cnt_adv, stop, take, ws_nxt;
  logic [1:0]        mode_q;
  logic              msb_q;
  logic [DATA_W-1:0] dat_ord;
  logic [SLOT_W-1:0] slot_word, sh_q;

  spi_i2s_frm_cnt #(
    .SLOT_W (SLOT_W),
    .NUM_CH (NUM_CH),
    .BW     (BW),
    .CW     (CW)
  ) u_frm_cnt (
    .clk       (i2s_clk_shft_tx),
    .rst       (rst),
    .clr       (cnt_clr),
    .adv       (cnt_adv),
    .last_bit  (last_bit),
    .last_slot (last_slot),
    .next_bcnt (next_bcnt),
    .next_scnt (next_scnt)
  );

  // State register.
  always_ff @(posedge i2s_clk_shft_tx) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a stop request only takes effect at the end of a frame.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (en)     state_nxt = ST_LOAD;
      ST_LOAD:  if (tx_vld) state_nxt = ST_SHIFT;
      ST_SHIFT: if (stop)   state_nxt = ST_IDLE;
      default:              state_nxt = ST_IDLE;
    endcase
  end

  // Outputs and strobes; tx_rdy is built from state/counters/en only, never tx_vld.
  always_comb begin
    busy    = (state != ST_IDLE);
    tx_rdy  = 1'b0;
    tx_ch   = '0;
    stop    = 1'b0;
    undrn   = 1'b0;
    cnt_clr = 1'b0;
    cnt_adv = 1'b0;
    case (state)
      ST_LOAD: begin
        tx_rdy  = !rst;
        cnt_clr = 1'b1;
      end
      ST_SHIFT: begin
        cnt_adv = 1'b1;
        if (last_bit) begin
          tx_ch = next_scnt;
          if (last_slot && !en) begin
            stop = 1'b1;
          end else begin
            tx_rdy = !rst;
            undrn  = !rst && !tx_vld;
          end
        end
      end
      default: ;
    endcase
    take = tx_rdy && tx_vld;
  end

  // Arrange the FIFO word in transmit order: first bit at the top, zero padding below.
  always_comb begin
    dat_ord = tx_dat;
    if (!msb_q) begin
      for (int i = 0; i < DATA_W; i++) dat_ord[i] = tx_dat[DATA_W-1-i];
    end
    slot_word = SLOT_W'(dat_ord) << (SLOT_W - DATA_W);
  end

  // Word-select level for the next cycle. I2S looks one bit further ahead so ws
  // leads the slot by one clock; TDM marks only the first bit of slot 0.
  always_comb begin
    ws_slot = next_scnt;
    if (next_bcnt == BW'(SLOT_W - 1))
      ws_slot = (next_scnt == CW'(NUM_CH - 1)) ? '0 : next_scnt + 1'b1;
    if (mode_q == MODE_TDM)      ws_nxt = (next_bcnt == '0) && (next_scnt == '0);
    else if (mode_q == MODE_I2S) ws_nxt = (ws_slot >= CW'(HALF));
    else                         ws_nxt = (next_scnt >= CW'(HALF));
    if (state == ST_LOAD) ws_nxt = (mode_q == MODE_TDM);
  end

  // Shift register, registered sdo/ws, and per-run latching of mode and bit order.
  always_ff @(posedge i2s_clk_shft_tx) begin
    if (rst) begin
      sdo    <= 1'b0;
      ws     <= 1'b0;
      sh_q   <= '0;
      mode_q <= MODE_I2S;
      msb_q  <= 1'b0;
    end else begin
      if (state == ST_IDLE && en) begin
        mode_q <= (mode == 2'd3) ? MODE_LJ : mode;
        msb_q  <= msb_lsb;
      end
      if (take) begin
        sdo  <= slot_word[SLOT_W-1];
        sh_q <= slot_word << 1;
        ws   <= ws_nxt;
      end else if (undrn) begin
        sdo  <= 1'b0;
        sh_q <= '0;
        ws   <= ws_nxt;
      end else if (state == ST_SHIFT && !stop) begin
        sdo  <= sh_q[SLOT_W-1];
        sh_q <= sh_q << 1;
        ws   <= ws_nxt;
      end else begin
        sdo <= 1'b0;
        ws  <= 1'b0;
      end
    end
  end

  // Saturating underflow counter; a clear coinciding with an underflow leaves one count.
  always_ff @(posedge i2s_clk_shft_tx) begin
    if (rst)
      undrn_cnt <= '0;
    else if (undrn_clr)
      undrn_cnt <= {7'd0, undrn};
    else if (undrn && undrn_cnt != 8'(UNDRN_MAX))
      undrn_cnt <= undrn_cnt + 8'd1;
  end

endmodule

// File: tb/tb_spi_i2s_tx_mc.sv
// Bench for spi_i2s_tx_mc: lane 0 is 16/16/2 (I2S/LJ, underflow, stop, reset),
// lane 1 is 24/32/4 (TDM, I2S, reserved mode). Each lane has a reference model
// that pushes expected sdo/ws bits onto a scoreboard queue at every slot pop.
module tb_spi_i2s_tx_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic       en_v   [2];
  logic       rst_v  [2];
  logic       clr_v  [2];
  logic [1:0] mode_v [2];
  logic       msb_v  [2];
  logic [31:0] wq0[$];
  logic [31:0] wq1[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int wq_size(input int g);
    return (g == 0) ? wq0.size() : wq1.size();
  endfunction

  function automatic logic [31:0] wq_head(input int g);
    if (g == 0) return (wq0.size() > 0) ? wq0[0] : 32'd0;
    return (wq1.size() > 0) ? wq1[0] : 32'd0;
  endfunction

  function automatic void wq_pop(input int g);
    if (g == 0) void'(wq0.pop_front());
    else        void'(wq1.pop_front());
  endfunction

  // Expected {sdo, ws} for bit i of slot k.
  function automatic logic [1:0] exp_bit(input logic [1:0] md, input logic msb,
                                         input int dw, input int sw, input int n,
                                         input logic [31:0] w, input int k, input int i);
    logic d, s;
    d = 1'b0;
    if (i < dw) d = msb ? w[dw-1-i] : w[i];
    if (md == 2'd2)                s = (k == 0 && i == 0);
    else if (md == 2'd0 && i == sw-1) s = (((k + 1) % n) >= n/2);
    else                           s = (k >= n/2);
    return {d, s};
  endfunction

  for (genvar G = 0; G < 2; G++) begin : g_lane
    localparam int DW  = (G == 0) ? 16 : 24;
    localparam int SW  = (G == 0) ? 16 : 32;
    localparam int N   = (G == 0) ? 2 : 4;
    localparam int CHW = (G == 0) ? 1 : 2;

    logic           tx_vld = 1'b0;
    logic [DW-1:0]  tx_dat = '0;
    logic           tx_rdy, sdo, ws, busy, undrn;
    logic [CHW-1:0] tx_ch;
    logic [7:0]     undrn_cnt;

    spi_i2s_tx_mc #(.DATA_W(DW), .SLOT_W(SW), .NUM_CH(N)) dut (
      .i2s_clk_shft_tx (clk),
      .rst             (rst_v[G]),
      .en              (en_v[G]),
      .mode            (mode_v[G]),
      .msb_lsb         (msb_v[G]),
      .tx_dat          (tx_dat),
      .tx_vld          (tx_vld),
      .tx_rdy          (tx_rdy),
      .tx_ch           (tx_ch),
      .sdo             (sdo),
      .ws              (ws),
      .busy            (busy),
      .undrn           (undrn),
      .undrn_clr       (clr_v[G]),
      .undrn_cnt       (undrn_cnt)
    );

    initial begin
      int mst, mb, ms, ucnt, kk;
      logic [1:0] m_mode, e;
      logic m_msb, er, eu, pend;
      logic [31:0] w;
      logic [1:0] eq[$];
      string p;
      mst = 0; mb = 0; ms = 0; ucnt = 0;
      m_mode = 2'd0; m_msb = 1'b0;
      p = $sformatf("g%0d_", G);
      forever begin
        @(negedge clk);
        er = !rst_v[G] && (mst == 1 ||
             (mst == 2 && mb == SW-1 && !(ms == N-1 && !en_v[G])));
        eu = er && mst == 2 && !tx_vld;
        chk({p, "tx_rdy"}, 32'(tx_rdy), 32'(er));
        chk({p, "busy"}, 32'(busy), 32'(mst != 0));
        e = (eq.size() > 0) ? eq.pop_front() : 2'b00;
        chk({p, "sdo"}, 32'(sdo), 32'(e[1]));
        chk({p, "ws"}, 32'(ws), 32'(e[0]));
        chk({p, "undrn"}, 32'(undrn), 32'(eu));
        chk({p, "undrn_cnt"}, 32'(undrn_cnt), 32'(ucnt));
        pend = 1'b0;
        if (er) begin
          kk = (mst == 1) ? 0 : (ms + 1) % N;
          chk({p, "tx_ch"}, 32'(tx_ch), 32'(kk));
          w = tx_vld ? wq_head(G) : 32'd0;
          if (tx_vld || mst == 2)
            for (int i = 0; i < SW; i++) eq.push_back(exp_bit(m_mode, m_msb, DW, SW, N, w, kk, i));
          pend = tx_vld;
        end
        if (rst_v[G])                 ucnt = 0;
        else if (clr_v[G])            ucnt = eu ? 1 : 0;
        else if (eu && ucnt < 255)    ucnt++;
        if (rst_v[G]) begin
          mst = 0; mb = 0; ms = 0; pend = 1'b0;
          eq.delete();
        end else begin
          case (mst)
            0: if (en_v[G]) begin mst = 1; m_mode = mode_v[G]; m_msb = msb_v[G]; end
            1: if (tx_vld) begin mst = 2; mb = 0; ms = 0; end
            default: begin
              if (mb == SW-1) begin
                mb = 0;
                if (ms == N-1) begin
                  ms = 0;
                  if (!en_v[G]) mst = 0;
                end else ms++;
              end else mb++;
            end
          endcase
        end
        @(posedge clk);
        #1;
        if (pend) wq_pop(G);
        #1;
        tx_vld = wq_size(G) > 0;
        tx_dat = DW'(wq_head(G));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      rst_v[g] = 1'b1; en_v[g] = 1'b0; clr_v[g] = 1'b0;
      mode_v[g] = 2'd0; msb_v[g] = 1'b1;
    end
    cyc(3);
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;
    cyc(3);

    // I2S MSB-first, en dropped at bcnt=3 of slot 0; third word must stay queued.
    wq0.push_back(32'hA5F0); wq0.push_back(32'h1234); wq0.push_back(32'hFFFF);
    mode_v[0] = 2'd0; msb_v[0] = 1'b1; en_v[0] = 1'b1;
    cyc(5);
    en_v[0] = 1'b0;
    cyc(40);
    chk("g0_no_extra_pop", 32'(wq0.size()), 32'd1);
    wq0.delete();
    cyc(3);

    // Left-justified, LSB-first.
    wq0.push_back(32'h0001); wq0.push_back(32'h8000);
    mode_v[0] = 2'd1; msb_v[0] = 1'b0; en_v[0] = 1'b1;
    cyc(5);
    en_v[0] = 1'b0;
    cyc(40);
    chk("g0_lj_pops", 32'(wq0.size()), 32'd0);

    // Underflow from slot 1 onward, saturation, then clear coinciding with an underflow.
    wq0.push_back(32'h1234);
    mode_v[0] = 2'd1; msb_v[0] = 1'b1; en_v[0] = 1'b1;
    cyc(4900);
    clr_v[0] = 1'b1;
    cyc(16);
    clr_v[0] = 1'b0;
    cyc(20);
    en_v[0] = 1'b0;
    cyc(40);

    // Reset in the middle of slot 0, then restart from slot 0.
    wq0.push_back(32'hC3C3); wq0.push_back(32'h0F0F); wq0.push_back(32'h7E81);
    mode_v[0] = 2'd0; msb_v[0] = 1'b1; en_v[0] = 1'b1;
    cyc(8);
    rst_v[0] = 1'b1; en_v[0] = 1'b0;
    cyc(1);
    rst_v[0] = 1'b0;
    cyc(2);
    en_v[0] = 1'b1;
    cyc(5);
    en_v[0] = 1'b0;
    cyc(40);
    chk("g0_restart_pops", 32'(wq0.size()), 32'd0);

    // TDM, 24-in-32, four slots, two frames.
    wq1.push_back(32'hFFFFFF); wq1.push_back(32'hFFFFFF);
    wq1.push_back(32'hFFFFFF); wq1.push_back(32'hFFFFFF);
    wq1.push_back(32'hABCDEF); wq1.push_back(32'h123456);
    wq1.push_back(32'h800001); wq1.push_back(32'h0F0F0F);
    mode_v[1] = 2'd2; msb_v[1] = 1'b1; en_v[1] = 1'b1;
    cyc(140);
    en_v[1] = 1'b0;
    cyc(140);
    chk("g1_tdm_pops", 32'(wq1.size()), 32'd0);

    // I2S LSB-first on four slots.
    wq1.push_back(32'h00A5C3); wq1.push_back(32'hF00001);
    wq1.push_back(32'h7FFFFE); wq1.push_back(32'h000100);
    mode_v[1] = 2'd0; msb_v[1] = 1'b0; en_v[1] = 1'b1;
    cyc(10);
    en_v[1] = 1'b0;
    cyc(140);
    chk("g1_i2s_pops", 32'(wq1.size()), 32'd0);

    // Reserved mode behaves as left-justified.
    wq1.push_back(32'h5A5A5A); wq1.push_back(32'h000001);
    wq1.push_back(32'h800000); wq1.push_back(32'h3C3C3C);
    mode_v[1] = 2'd3; msb_v[1] = 1'b1; en_v[1] = 1'b1;
    cyc(10);
    en_v[1] = 1'b0;
    cyc(140);
    chk("g1_rsvd_pops", 32'(wq1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_i2s_tx_mc.md
Name: spi_i2s_tx_mc

Overview:
Parametrised multi-channel serial transmit shifter, the successor to the fixed 32-bit I2S/SPI TX shifter. It sits between the TX FIFO (valid/ready pop interface) and the serial pad. It serialises NUM_CH slots per frame in I2S, left-justified or TDM framing, with MSB/LSB-first order and zero padding to SLOT_W. It adds underflow detection, a saturating underflow counter and graceful stop at a frame boundary.

Parameters:
DATA_W, 32, bits of valid data per slot word
SLOT_W, 32, bit clocks per slot; must be >= DATA_W
NUM_CH, 2, slots per frame; even and >= 2 for I2S/LJ, >= 1 for TDM

Ports:
i2s_clk_shft_tx  in  1  bit clock; all logic on rising edge
rst  in  1  synchronous active-high reset
en  in  1  run request; sampled every cycle
mode  in  2  0=I2S, 1=left-justified, 2=TDM, 3=reserved (treated as LJ)
msb_lsb  in  1  1=MSB first, 0=LSB first
tx_dat  in  DATA_W  FIFO head word
tx_vld  in  1  FIFO not empty
tx_rdy  out  1  pop strobe; word consumed when tx_vld & tx_rdy
tx_ch  out  clog2(NUM_CH) (min 1)  slot index of the word being requested
sdo  out  1  serial data, driven directly from a register
ws  out  1  word select / frame sync, driven directly from a register
busy  out  1  high in LOAD and SHIFT
undrn  out  1  one-cycle pulse per underflowed slot
undrn_clr  in  1  clears undrn_cnt
undrn_cnt  out  8  saturating underflow count

Behaviour:
- Reset: state=IDLE; sdo, ws, tx_rdy, busy, undrn = 0; undrn_cnt = 0; tx_ch = 0; bit and slot counters = 0. rst mid-frame aborts on the next edge and pops nothing.
- Clock and reset: one clock; reset is synchronous and active-high.
- States:
  - IDLE -> LOAD when en = 1. mode and msb_lsb are latched on this transition and held until the next return to IDLE.
  - LOAD: tx_rdy = 1, tx_ch = 0. Waits for tx_vld with no underflow flagged. On handshake (cycle T): capture the word, bcnt = 0, scnt = 0, go to SHIFT. Bit 0 of slot 0 appears on sdo in cycle T+1.
  - SHIFT: one bit per cycle. bcnt runs 0..SLOT_W-1. At bcnt = SLOT_W-1, scnt advances and wraps at NUM_CH-1 (frame end).
- Slot boundary (SHIFT, bcnt = SLOT_W-1):
  - tx_rdy = 1 and tx_ch = next slot index, unless this is the frame end and en = 0. In that case tx_rdy = 0 and the next state is IDLE.
  - If tx_vld = 0 while tx_rdy = 1: the next slot transmits all zeros, undrn pulses in that same cycle, and undrn_cnt increments (saturates at 255).
  - undrn_clr and a new underflow in the same cycle give undrn_cnt = 1.
- Bit order:
  - MSB-first: tx_dat[DATA_W-1] first.
  - LSB-first: tx_dat[0] first.
  - In both orders the DATA_W data bits come first in the slot, followed by SLOT_W-DATA_W zeros.
- Framing (cycle-level, relative to the first data bit of slot k):
  - LJ: ws = 0 for slots 0..NUM_CH/2-1 and 1 otherwise. ws changes in the same cycle as the first bit of the slot.
  - I2S: same ws levels as LJ, but ws changes one cycle earlier, at the last bit of the previous slot. ws is therefore computed from next-count values.
  - TDM: ws = 1 only during the first bit of slot 0, otherwise 0.
- en = 0 mid-frame: the current frame completes. busy falls in the cycle after the last bit of slot NUM_CH-1, and sdo = 0 in IDLE. If en is reasserted in IDLE, a new LOAD begins.
- tx_rdy is a Moore output: it never depends combinationally on tx_vld.

Decomposition:
- Package spi_i2s_pkg holds:
  - mode encodings MODE_I2S, MODE_LJ, MODE_TDM
  - state encodings ST_IDLE, ST_LOAD, ST_SHIFT
  - clog2 helper function
  - UNDRN_MAX = 255
- One sub-module, spi_i2s_frm_cnt: bit/slot counters with last_bit, last_slot, next_scnt and next_bcnt outputs, parametrised by SLOT_W and NUM_CH.
- The FSM, shift register, framing and underflow logic live in the top level.

Test Plan:
1. DATA_W=SLOT_W=16, NUM_CH=2, I2S, MSB-first, words 0xA5F0 then 0x1234 -> sdo serialises 1010010111110000 then 0001001000110100. ws rises in the cycle of the last bit of 0xA5F0, one cycle before the first 0 of 0x1234.
2. LJ, LSB-first, word 0x0001 -> sdo = 1 then fifteen 0s. ws toggles coincident with the first bit of each slot.
3. tx_vld held low at the slot-0 boundary -> slot 1 is 16 zeros, undrn pulses once, undrn_cnt = 1. Then force 300 underflows -> undrn_cnt = 255. Assert undrn_clr together with an underflow -> undrn_cnt = 1.
4. DATA_W=24, SLOT_W=32, NUM_CH=4, TDM, word 0xFFFFFF -> 24 ones then 8 zeros per slot. ws is high exactly 1 cycle every 128 cycles, on the first bit of slot 0. tx_ch sequence is 1, 2, 3, 0.
5. en dropped at bcnt=3 of slot 0 -> slot 1 still transmits fully. tx_rdy stays 0 at the frame end, busy falls one cycle after the last bit, and no extra pop occurs.
6. rst asserted mid-SHIFT -> on the next edge sdo=0, ws=0, busy=0 and tx_rdy=0. Restart via en gives correct framing from slot 0.
